// File: rtl/poly_audio_pkg.sv
// Shared types, encodings and tuning constants for the polyphonic tone generator.
package poly_audio_pkg;

   localparam int unsigned MAX_VOICES = 8;
   localparam int unsigned PHASE_W    = 32;
   localparam int unsigned LEVEL_W    = 16;
   localparam int unsigned WAVE_W     = 14;
   localparam int unsigned SINE_A_W   = 12;
   localparam int unsigned PROD_W     = 31;

   typedef enum logic [1:0] {
      ENV_IDLE    = 2'd0,
      ENV_ATTACK  = 2'd1,
      ENV_SUSTAIN = 2'd2,
      ENV_RELEASE = 2'd3
   } env_state_e;

   typedef enum logic [1:0] {
      WAVE_SINE   = 2'd0,
      WAVE_RAMP   = 2'd1,
      WAVE_SQUARE = 2'd2,
      WAVE_TRI    = 2'd3
   } wave_e;

   // Per-voice payload handed from the waveform stage to the multiplier stage.
   typedef struct packed {
      logic signed [WAVE_W-1:0] wave;
      logic [LEVEL_W-1:0]       level;
   } voice_e1_t;

   localparam logic [PHASE_W-1:0] TUNE [MAX_VOICES] = '{
      32'd107786375, 32'd101736857, 32'd90637199, 32'd80749505,
      32'd71891779,  32'd67874903,  32'd60459132, 32'd53867335
   };

   // Map the top phase bits to the selected waveform; sine comes from the lookup.
   function automatic logic signed [WAVE_W-1:0] shape(input wave_e sel,
                                                      input logic [WAVE_W-1:0] p,
                                                      input logic signed [WAVE_W-1:0] sine);
      logic signed [WAVE_W+1:0] twice;
      logic signed [WAVE_W+1:0] fold;
      logic signed [WAVE_W-1:0] w;
      twice = $signed({2'b00, p[WAVE_W-2:0], 1'b0});
      fold  = '0;
      w     = sine;
      unique case (sel)
         WAVE_SINE:   w = sine;
         WAVE_RAMP:   w = {~p[WAVE_W-1], p[WAVE_W-2:0]};
         WAVE_SQUARE: w = p[WAVE_W-1] ? -14'sd8191 : 14'sd8191;
         WAVE_TRI: begin
            fold = p[WAVE_W-1] ? (16'sd8191 - twice) : (twice - 16'sd8192);
            if (fold > 16'sd8191)
               w = 14'sd8191;
            else if (fold < -16'sd8192)
               w = -14'sd8192;
            else
               w = fold[WAVE_W-1:0];
         end
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sine.sv
// Sine lookup: 12-bit phase in, signed 14-bit sample out, parabolic per half period.
module sine
   import poly_audio_pkg::*;
(
   input  logic [SINE_A_W-1:0]      phase,
   output logic signed [WAVE_W-1:0] value_c
);

   logic [SINE_A_W-2:0] x;
   logic [21:0]         y;
   logic [14:0]         mag;
   logic [12:0]         mag_clip;

   always_comb begin
      x        = phase[SINE_A_W-2:0];
      y        = 22'(x) * (22'd2048 - 22'(x));
      mag      = 15'(y >> 7);
      mag_clip = (mag > 15'd8191) ? 13'h1FFF : mag[12:0];
      value_c  = phase[SINE_A_W-1] ? -$signed({1'b0, mag_clip}) : $signed({1'b0, mag_clip});
   end

endmodule

// File: rtl/voice_env.sv
// Per-voice envelope: attack/sustain/release FSM and level register, stepped on the sample strobe.
module voice_env
   import poly_audio_pkg::*;
#(
   parameter logic [LEVEL_W-1:0] ATK_STEP = 16'd4096,
   parameter logic [LEVEL_W-1:0] REL_STEP = 16'd1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ena,
   input  logic               key,
   output env_state_e         state,
   output logic [LEVEL_W-1:0] level,
   output logic               active,
   output logic               start_c
);

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   env_state_e         state_nxt;
   logic [LEVEL_W-1:0] level_nxt;
   logic [LEVEL_W:0]   atk_sum_c;
   logic [LEVEL_W-1:0] atk_lvl_c;
   logic [LEVEL_W-1:0] rel_lvl_c;

   always_comb begin
      atk_sum_c = {1'b0, level} + {1'b0, ATK_STEP};
      atk_lvl_c = atk_sum_c[LEVEL_W] ? LEVEL_MAX : atk_sum_c[LEVEL_W-1:0];
      rel_lvl_c = (level > REL_STEP) ? (level - REL_STEP) : '0;
   end

   // Key release is checked before saturation so it wins on the same strobe.
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      start_c   = 1'b0;
      if (ena) begin
         unique case (state)
            ENV_IDLE: begin
               if (key) begin
                  start_c   = 1'b1;
                  level_nxt = atk_lvl_c;
                  state_nxt = ENV_ATTACK;
               end
            end
            ENV_ATTACK: begin
               if (!key) begin
                  level_nxt = rel_lvl_c;
                  state_nxt = ENV_RELEASE;
               end else begin
                  level_nxt = atk_lvl_c;
                  if (atk_lvl_c == LEVEL_MAX)
                     state_nxt = ENV_SUSTAIN;
               end
            end
            ENV_SUSTAIN: begin
               if (!key) begin
                  level_nxt = rel_lvl_c;
                  state_nxt = ENV_RELEASE;
               end
            end
            ENV_RELEASE: begin
               if (key) begin
                  level_nxt = atk_lvl_c;
                  state_nxt = ENV_ATTACK;
               end else begin
                  level_nxt = rel_lvl_c;
                  if (rel_lvl_c == '0)
                     state_nxt = ENV_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ENV_IDLE;
         level  <= '0;
         active <= 1'b0;
      end else begin
         state  <= state_nxt;
         level  <= level_nxt;
         active <= (state_nxt != ENV_IDLE);
      end
   end

endmodule

// File: rtl/poly_audiogen.sv
// Polyphonic tone generator: per-voice oscillator and envelope, 3-stage pipeline to a saturated stereo mix.
module poly_audiogen
   import poly_audio_pkg::*;
#(
   parameter int unsigned NVOICE   = 8,
   parameter int unsigned OUT_W    = 24,
   parameter logic [15:0] ATK_STEP = 16'd4096,
   parameter logic [15:0] REL_STEP = 16'd1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ena,
   input  logic [NVOICE-1:0]       sw_tones,
   input  logic [1:0]              wave_sel,
   input  logic                    stereo,
   output logic signed [OUT_W-1:0] l_data,
   output logic signed [OUT_W-1:0] r_data,
   output logic                    out_valid,
   output logic [NVOICE-1:0]       active
);

   localparam int unsigned SHIFT   = 30 - OUT_W;
   localparam int unsigned VOICE_W = OUT_W + 1;
   localparam int unsigned SUM_W   = VOICE_W + $clog2(NVOICE) + 1;
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

   logic s1, s2, s3;
   logic signed [VOICE_W-1:0] vsamp [NVOICE];
   logic signed [SUM_W-1:0]   sum_even_c, sum_odd_c, mix_c, sum_l_c, sum_r_c;

   for (genvar v = 0; v < NVOICE; v++) begin : g_voice
      env_state_e                state;
      logic [LEVEL_W-1:0]        level;
      logic                      env_active;
      logic                      start_c;
      logic [PHASE_W-1:0]        phase;
      logic signed [WAVE_W-1:0]  sine_c;
      voice_e1_t                 e1;
      logic signed [PROD_W-1:0]  prod_c;
      logic signed [VOICE_W-1:0] samp;

      voice_env #(
         .ATK_STEP (ATK_STEP),
         .REL_STEP (REL_STEP)
      ) u_env (
         .clk     (clk),
         .reset   (reset),
         .ena     (ena),
         .key     (sw_tones[v]),
         .state   (state),
         .level   (level),
         .active  (env_active),
         .start_c (start_c)
      );

      assign active[v] = env_active;

      // Phase restarts on a fresh note, otherwise runs only while the voice sounds.
      always_ff @(posedge clk) begin
         if (reset)
            phase <= '0;
         else if (start_c)
            phase <= '0;
         else if (ena && state != ENV_IDLE)
            phase <= phase + TUNE[v];
      end

      sine u_sine (
         .phase   (phase[PHASE_W-1:PHASE_W-SINE_A_W]),
         .value_c (sine_c)
      );

      always_ff @(posedge clk) begin
         if (reset) begin
            e1 <= '0;
         end else if (s1) begin
            e1.wave  <= shape(wave_e'(wave_sel), phase[PHASE_W-1:PHASE_W-WAVE_W], sine_c);
            e1.level <= (state == ENV_IDLE) ? '0 : level;
         end
      end

      assign prod_c = PROD_W'($signed(e1.wave)) * PROD_W'($signed({1'b0, e1.level}));

      always_ff @(posedge clk) begin
         if (reset)
            samp <= '0;
         else if (s2)
            samp <= VOICE_W'(prod_c >>> SHIFT);
      end

      assign vsamp[v] = samp;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= ena;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Even voices feed left and odd voices right in stereo; otherwise both get the full mix.
   always_comb begin
      sum_even_c = '0;
      sum_odd_c  = '0;
      for (int v = 0; v < NVOICE; v++) begin
         if (v % 2 == 0)
            sum_even_c = sum_even_c + SUM_W'(vsamp[v]);
         else
            sum_odd_c = sum_odd_c + SUM_W'(vsamp[v]);
      end
      mix_c   = sum_even_c + sum_odd_c;
      sum_l_c = stereo ? sum_even_c : mix_c;
      sum_r_c = stereo ? sum_odd_c : mix_c;
   end

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [SUM_W-1:0] x);
      logic signed [SUM_W-1:0] y;
      if (x > SAT_MAX)
         y = SAT_MAX;
      else if (x < SAT_MIN)
         y = SAT_MIN;
      else
         y = x;
      return y[OUT_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         l_data    <= '0;
         r_data    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s3;
         if (s3) begin
            l_data <= sat(sum_l_c);
            r_data <= sat(sum_r_c);
         end
      end
   end

endmodule

// File: doc/poly_audiogen.md
POLY_AUDIOGEN -- requirements
Module: poly_audiogen

Interface
REQ-001 Parameter NVOICE, default 8, SHALL set the number of simultaneous voices (legal 1..8).
REQ-002 Parameter OUT_W, default 24, SHALL set the signed output sample width (legal 16..30).
REQ-003 Parameter ATK_STEP, default 16'd4096, SHALL set the envelope attack increment per ena.
REQ-004 Parameter REL_STEP, default 16'd1024, SHALL set the envelope release decrement per ena.
REQ-005 clk  in  1  system clock; the block SHALL use one clock and be rising-edge only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ena  in  1  sample-rate strobe, one clk wide, spaced at least 4 clk apart.
REQ-008 sw_tones  in  NVOICE  key-down per voice; bit v gates voice v.
REQ-009 wave_sel  in  2  waveform: 0 sine, 1 ramp, 2 square, 3 triangle; applies to all voices.
REQ-010 stereo  in  1  0 = full mix on both channels; 1 = even voices left, odd voices right.
REQ-011 l_data, r_data  out  OUT_W each  signed audio samples.
REQ-012 out_valid  out  1  one-clk pulse when l_data/r_data update.
REQ-013 active  out  NVOICE  bit v high while voice v envelope is not IDLE.

Function
REQ-014 Per voice: 32-bit phase accumulator, increment = TUNE[v] from package, advanced on ena only while the voice is not IDLE.
REQ-015 Phase SHALL wrap modulo 2^32, and SHALL be cleared to 0 on the IDLE->ATTACK transition.
REQ-016 Per voice envelope FSM (evaluated on ena): IDLE -> ATTACK when key=1.
REQ-017 ATTACK: level += ATK_STEP, saturating at 16'hFFFF; reaching 16'hFFFF -> SUSTAIN.
REQ-018 ATTACK or SUSTAIN with key=0 -> RELEASE; key release SHALL take priority over simultaneous saturation.
REQ-019 RELEASE: level -= REL_STEP, floored at 0; reaching 0 -> IDLE; key=1 -> ATTACK without phase reset (retrigger).
REQ-020 Waveforms from p = phase[31:18], 14-bit signed: sine = existing sine lookup on phase[31:20].
REQ-021 Ramp = {~p[13], p[12:0]}.
REQ-022 Square = +8191 if p[13]=0, else -8191.
REQ-023 Triangle = ramp folded: p[13]=0 gives 2*p[12:0]-8192, else 8191-2*p[12:0], clipped to 14-bit range.
REQ-024 Voice sample = (wave * level) >>> (30-OUT_W), arithmetic shift of the signed 31-bit product.
REQ-025 Sum voices per channel per REQ-010 with log2(NVOICE)+1 guard bits; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 Pipeline: E0 = ena cycle (phase/envelope update); E1 = waveform registered; E2 = product registered; E3 = saturated sums to l_data/r_data with out_valid=1.
REQ-027 out_valid is high only in E3; outputs SHALL hold between updates; IDLE voices SHALL contribute 0.

Reset
REQ-028 Reset SHALL force all phases 0, levels 0, FSMs IDLE, pipeline cleared; l_data=0, r_data=0, out_valid=0, active=0 on the next clk.
REQ-029 Reset mid-operation SHALL abort any in-flight pipeline sample (no out_valid after reset).
REQ-030 ena during reset SHALL be ignored.

Structure
REQ-031 Package poly_audio_pkg SHALL hold the envelope state enum, wave_sel encodings, and TUNE[0..7] = 107786375, 101736857, 90637199, 80749505, 71891779, 67874903, 60459132, 53867335.
REQ-032 One sub-module, voice_env (envelope FSM plus level register), SHALL be instantiated NVOICE times; the sine lookup SHALL be the existing sine module.

Verification
REQ-033 Reset asserted 2 clk -> all outputs 0, active=0, no out_valid.
REQ-034 sw_tones[0]=1, defaults -> level 65535 and SUSTAIN on the 16th ena; then release -> IDLE and active[0]=0 on the 64th ena.
REQ-035 wave_sel=2, voice 0 sustained, p[13]=0 -> l_data=8387456 exactly 3 clk after ena; p[13]=1 -> -8387457.
REQ-036 Voices 0 and 2 sustained square, same phase, stereo=0 -> l_data=r_data=8388607 (saturated).
REQ-037 stereo=1, only voice 1 sustained -> l_data=0 and r_data nonzero every sample.
REQ-038 Key released on the same ena that attack saturates -> RELEASE next; reset pulse mid-release -> outputs 0, out_valid suppressed.
